// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and multiply-group types.
// Used by riscv_mul_iter (optional operand/product reuse cache: RISCV_MUL_FUSE_EN).
package riscv_pkg;

    localparam logic [1:0] RV32I = 2'b01;
    localparam logic [1:0] RV64I = 2'b10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_MUL     = 3'b000;
    localparam logic [2:0] F3_MULH    = 3'b001;
    localparam logic [2:0] F3_MULHSU  = 3'b010;
    localparam logic [2:0] F3_MULHU   = 3'b011;
    localparam logic [2:0] F3_MULW    = 3'b000;

    typedef enum logic [2:0] {
        MOP_MUL,
        MOP_MULH,
        MOP_MULHSU,
        MOP_MULHU,
        MOP_MULW
    } mul_op_t;

    // Operand-transform class; ops sharing a class produce the same full product.
    typedef enum logic [1:0] {
        CLS_SS,
        CLS_SU,
        CLS_UU,
        CLS_W
    } mul_cls_t;

    typedef struct packed {
        logic    valid;
        mul_op_t op;
    } mul_dec_t;

    function automatic mul_dec_t decode_mul(input logic [31:0] instr, input logic mulw_ok);
        mul_dec_t d;
        d.valid = 1'b0;
        d.op    = MOP_MUL;
        if (instr[31:25] == F7_MULDIV) begin
            if (instr[6:0] == OPC_OP) begin
                case (instr[14:12])
                    F3_MUL:    begin d.valid = 1'b1; d.op = MOP_MUL;    end
                    F3_MULH:   begin d.valid = 1'b1; d.op = MOP_MULH;   end
                    F3_MULHSU: begin d.valid = 1'b1; d.op = MOP_MULHSU; end
                    F3_MULHU:  begin d.valid = 1'b1; d.op = MOP_MULHU;  end
                    default:   d.valid = 1'b0;
                endcase
            end else if ((instr[6:0] == OPC_OP32) && (instr[14:12] == F3_MULW) && mulw_ok) begin
                d.valid = 1'b1;
                d.op    = MOP_MULW;
            end
        end
        return d;
    endfunction

    function automatic mul_cls_t mul_class(input mul_op_t op);
        case (op)
            MOP_MULHSU: return CLS_SU;
            MOP_MULHU:  return CLS_UU;
            MOP_MULW:   return CLS_W;
            default:    return CLS_SS;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mul_step.sv
// One radix-2^RADIX_BITS iteration: add mcand*digit into the high accumulator
// half, then shift the whole accumulator right by one digit.
module riscv_mul_step #(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 4
) (
    input  logic [XLEN-1:0]       mcand,
    input  logic [XLEN-1:0]       acc_hi,
    input  logic [XLEN-1:0]       acc_lo,
    input  logic [RADIX_BITS-1:0] digit,
    output logic [XLEN-1:0]       acc_hi_nxt,
    output logic [XLEN-1:0]       acc_lo_nxt
);

    localparam int SW = XLEN + RADIX_BITS;

    logic [SW-1:0] partial;
    logic [SW-1:0] sum;
    logic          unused_lo;

    always_comb begin
        partial = {{RADIX_BITS{1'b0}}, mcand} * {{XLEN{1'b0}}, digit};
        sum     = {{RADIX_BITS{1'b0}}, acc_hi} + partial;
    end

    assign acc_hi_nxt = sum[SW-1:RADIX_BITS];
    assign acc_lo_nxt = {sum[RADIX_BITS-1:0], acc_lo[XLEN-1:RADIX_BITS]};

    // The lowest digit of the accumulator falls off the end each step.
    assign unused_lo  = ^acc_lo[RADIX_BITS-1:0];

endmodule

// File: rtl/riscv_mul_iter.sv
// Iterative multiplier for MUL/MULH/MULHSU/MULHU/MULW in the EX stage.
// Optional last-product reuse cache enabled by defining RISCV_MUL_FUSE_EN.
//
// state | meaning
// IDLE  | waiting; captures a valid op, zero/cached ops complete here
// BUSY  | one radix digit consumed per cycle until cnt reaches zero
// DONE  | sign fix-up and result select, pulse mul_bubble low
module riscv_mul_iter
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 4,
    parameter int EARLY_OUT  = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            mul_stall,
    input  logic            id_bubble,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [1:0]      st_xlen,
    output logic            mul_bubble,
    output logic [XLEN-1:0] mul_r
);

    localparam int ITER   = XLEN / RADIX_BITS;
    localparam int ITER_W = 32 / RADIX_BITS;
    localparam int CNT_W  = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ITER - 1);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(ITER_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] absv(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] sel_result(input mul_op_t op, input logic [2*XLEN-1:0] p);
        case (op)
            MOP_MUL:  return p[XLEN-1:0];
            MOP_MULW: return sext32(p[31:0]);
            default:  return p[2*XLEN-1:XLEN];
        endcase
    endfunction

    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [XLEN-1:0]   mcand_q,  mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [2*XLEN-1:0] acc_q,    acc_d;
    logic              neg_q,    neg_d;
    mul_op_t           op_q,     op_d;
    logic              stall_q,  stall_d;
    logic              bubble_q, bubble_d;
    logic [XLEN-1:0]   r_q,      r_d;

    mul_dec_t          dec;
    logic [XLEN-1:0]   tr_a, tr_b;
    logic              tr_neg;
    logic              start, zero_out, fuse_hit, capture, done_ok;
    logic [2*XLEN-1:0] fuse_p;
    logic [2*XLEN-1:0] p_mag, p_fin;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic              unused_instr;

    assign dec          = decode_mul(id_instr, (XLEN == 64) && (st_xlen != RV32I));
    assign unused_instr = ^{id_instr[24:15], id_instr[11:7]};

    always_comb begin
        tr_a   = absv(opA);
        tr_b   = absv(opB);
        tr_neg = opA[XLEN-1] ^ opB[XLEN-1];
        case (dec.op)
            MOP_MULW: begin
                tr_a   = absv(sext32(opA[31:0]));
                tr_b   = absv(sext32(opB[31:0]));
                tr_neg = opA[31] ^ opB[31];
            end
            MOP_MULHU: begin
                tr_a   = opA;
                tr_b   = opB;
                tr_neg = 1'b0;
            end
            MOP_MULHSU: begin
                tr_b   = opB;
                tr_neg = opA[XLEN-1];
            end
            default: ;
        endcase
    end

    assign start    = (state_q == S_IDLE) && !ex_stall && !id_bubble && dec.valid && !flush;
    assign zero_out = (EARLY_OUT != 0) && ((tr_a == '0) || (tr_b == '0));
    assign capture  = start && !zero_out && !fuse_hit;
    assign done_ok  = (state_q == S_DONE) && !flush;

    // MULW runs only 32 bits of shifts, so its product sits XLEN-32 bits high.
    always_comb begin
        p_mag = (op_q == MOP_MULW) ? (acc_q >> (XLEN - 32)) : acc_q;
        p_fin = neg_q ? -p_mag : p_mag;
    end

    riscv_mul_step #(
        .XLEN       (XLEN),
        .RADIX_BITS (RADIX_BITS)
    ) u_step (
        .mcand      (mcand_q),
        .acc_hi     (acc_q[2*XLEN-1:XLEN]),
        .acc_lo     (acc_q[XLEN-1:0]),
        .digit      (mplier_q[RADIX_BITS-1:0]),
        .acc_hi_nxt (step_hi),
        .acc_lo_nxt (step_lo)
    );

`ifdef RISCV_MUL_FUSE_EN
    logic              fc_vld_q, fc_vld_d;
    logic [XLEN-1:0]   fc_a_q,   fc_a_d;
    logic [XLEN-1:0]   fc_b_q,   fc_b_d;
    mul_cls_t          fc_cls_q, fc_cls_d;
    logic              fc_neg_q, fc_neg_d;
    logic [2*XLEN-1:0] fc_p_q,   fc_p_d;
    logic [XLEN-1:0]   raw_a_q,  raw_a_d;
    logic [XLEN-1:0]   raw_b_q,  raw_b_d;

    assign fuse_hit = fc_vld_q && (fc_a_q == opA) && (fc_b_q == opB)
                    && (fc_cls_q == mul_class(dec.op)) && (fc_neg_q == tr_neg);
    assign fuse_p   = fc_p_q;

    always_comb begin
        raw_a_d  = capture ? opA : raw_a_q;
        raw_b_d  = capture ? opB : raw_b_q;
        fc_vld_d = fc_vld_q;
        fc_a_d   = fc_a_q;
        fc_b_d   = fc_b_q;
        fc_cls_d = fc_cls_q;
        fc_neg_d = fc_neg_q;
        fc_p_d   = fc_p_q;
        if (done_ok) begin
            fc_vld_d = 1'b1;
            fc_a_d   = raw_a_q;
            fc_b_d   = raw_b_q;
            fc_cls_d = mul_class(op_q);
            fc_neg_d = neg_q;
            fc_p_d   = p_fin;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fc_vld_q <= 1'b0;
            fc_a_q   <= '0;
            fc_b_q   <= '0;
            fc_cls_q <= CLS_SS;
            fc_neg_q <= 1'b0;
            fc_p_q   <= '0;
            raw_a_q  <= '0;
            raw_b_q  <= '0;
        end else begin
            fc_vld_q <= fc_vld_d;
            fc_a_q   <= fc_a_d;
            fc_b_q   <= fc_b_d;
            fc_cls_q <= fc_cls_d;
            fc_neg_q <= fc_neg_d;
            fc_p_q   <= fc_p_d;
            raw_a_q  <= raw_a_d;
            raw_b_q  <= raw_b_d;
        end
    end
`else
    assign fuse_hit = 1'b0;
    assign fuse_p   = '0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        op_d     = op_q;
        stall_d  = stall_q;
        bubble_d = 1'b1;
        r_d      = r_q;
        case (state_q)
            S_IDLE: begin
                if (start && (zero_out || fuse_hit)) begin
                    r_d      = zero_out ? '0 : sel_result(dec.op, fuse_p);
                    bubble_d = 1'b0;
                end else if (capture) begin
                    mcand_d  = tr_a;
                    mplier_d = tr_b;
                    neg_d    = tr_neg;
                    op_d     = dec.op;
                    acc_d    = '0;
                    cnt_d    = (dec.op == MOP_MULW) ? CNT_WORD : CNT_FULL;
                    stall_d  = 1'b1;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    stall_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    acc_d    = {step_hi, step_lo};
                    mplier_d = mplier_q >> RADIX_BITS;
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                stall_d = 1'b0;
                state_d = S_IDLE;
                if (!flush) begin
                    r_d      = sel_result(op_q, p_fin);
                    bubble_d = 1'b0;
                end
            end
            default: begin
                stall_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            op_q     <= MOP_MUL;
            stall_q  <= 1'b0;
            bubble_q <= 1'b1;
            r_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
            r_q      <= r_d;
        end
    end

    assign mul_stall  = stall_q;
    assign mul_bubble = bubble_q;
    assign mul_r      = r_q;

endmodule

// File: tb/tb_riscv_mul_iter.sv
// Directed bench for riscv_mul_iter: three instances (32/r4, 32/r4 without
// early-out, 64/r8) sharing one stimulus bus; only the selected one sees id_bubble low.
module tb_riscv_mul_iter;
    import riscv_pkg::*;

    localparam logic [31:0] I_MUL    = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] I_MULH   = {7'b0000001, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011};
    localparam logic [31:0] I_MULHSU = {7'b0000001, 5'd2, 5'd1, 3'b010, 5'd3, 7'b0110011};
    localparam logic [31:0] I_MULHU  = {7'b0000001, 5'd2, 5'd1, 3'b011, 5'd3, 7'b0110011};
    localparam logic [31:0] I_MULW   = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0111011};
    localparam logic [31:0] I_ADD    = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};

`ifdef RISCV_MUL_FUSE_EN
    localparam int FUSE_ST = 0;
`else
    localparam int FUSE_ST = 9;
`endif

    logic        clk = 1'b0;
    logic        rstn, ex_stall, flush;
    logic [2:0]  bub;
    logic [31:0] instr;
    logic [63:0] a, b;
    logic [1:0]  st;
    logic        stl0, stl1, stl2, bb0, bb1, bb2;
    logic [31:0] r0, r1;
    logic [63:0] r2;
    int          total, bad;

    always #5 clk = ~clk;

    riscv_mul_iter #(.XLEN(32), .RADIX_BITS(4), .EARLY_OUT(1)) dut (
        .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .flush(flush), .mul_stall(stl0),
        .id_bubble(bub[0]), .id_instr(instr), .opA(a[31:0]), .opB(b[31:0]),
        .st_xlen(st), .mul_bubble(bb0), .mul_r(r0));

    riscv_mul_iter #(.XLEN(32), .RADIX_BITS(4), .EARLY_OUT(0)) dut_neo (
        .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .flush(flush), .mul_stall(stl1),
        .id_bubble(bub[1]), .id_instr(instr), .opA(a[31:0]), .opB(b[31:0]),
        .st_xlen(st), .mul_bubble(bb1), .mul_r(r1));

    riscv_mul_iter #(.XLEN(64), .RADIX_BITS(8), .EARLY_OUT(1)) dut64 (
        .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .flush(flush), .mul_stall(stl2),
        .id_bubble(bub[2]), .id_instr(instr), .opA(a), .opB(b),
        .st_xlen(st), .mul_bubble(bb2), .mul_r(r2));

    function automatic logic get_stall(int s);
        case (s)
            0:       return stl0;
            1:       return stl1;
            default: return stl2;
        endcase
    endfunction

    function automatic logic get_bub(int s);
        case (s)
            0:       return bb0;
            1:       return bb1;
            default: return bb2;
        endcase
    endfunction

    function automatic logic [63:0] get_r(int s);
        case (s)
            0:       return {32'h0, r0};
            1:       return {32'h0, r1};
            default: return r2;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input int s, input logic [31:0] ins, input logic [63:0] va,
                          input logic [63:0] vb, input logic [1:0] vst,
                          input logic [63:0] exp, input int exp_st, input string nm);
        int n;
        instr = ins; a = va; b = vb; st = vst; bub[s] = 1'b0;
        @(posedge clk); #1;
        bub = 3'b111;
        n = 0;
        while (get_stall(s) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " stall_cycles"}, 64'(n), 64'(exp_st));
        chk({nm, " result"}, get_r(s), exp);
        chk({nm, " bubble_low"}, {63'h0, get_bub(s)}, 64'h0);
        @(posedge clk); #1;
        chk({nm, " bubble_back"}, {63'h0, get_bub(s)}, 64'h1);
    endtask

    task automatic ignore_op(input int s, input logic [31:0] ins, input logic [63:0] va,
                             input logic [63:0] vb, input logic [1:0] vst,
                             input logic [63:0] exp_r, input string nm);
        instr = ins; a = va; b = vb; st = vst; bub[s] = 1'b0;
        @(posedge clk); #1;
        chk({nm, " stall"}, {63'h0, get_stall(s)}, 64'h0);
        chk({nm, " bubble"}, {63'h0, get_bub(s)}, 64'h1);
        @(posedge clk); #1;
        bub = 3'b111;
        chk({nm, " r_kept"}, get_r(s), exp_r);
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [63:0] va;
        logic [63:0] vb;
        logic [63:0] exp;
        int          stalls;
    } vec_t;

    localparam int NV = 13;
    vec_t vt [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  saw;
        total = 0; bad = 0;

        vt[0]  = '{I_MUL,    64'h3,        64'hFFFFFFFB, 64'hFFFFFFF1, 9};
        vt[1]  = '{I_MULH,   64'h80000000, 64'h80000000, 64'h40000000, 9};
        vt[2]  = '{I_MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 9};
        vt[3]  = '{I_MULHSU, 64'hFFFFFFFF, 64'h2,        64'hFFFFFFFF, 9};
        vt[4]  = '{I_MUL,    64'h1234,     64'h0,        64'h0,        0};
        vt[5]  = '{I_MULH,   64'h0,        64'h5,        64'h0,        0};
        vt[6]  = '{I_MUL,    64'hFFFFFFFF, 64'hFFFFFFFF, 64'h1,        9};
        vt[7]  = '{I_MULH,   64'h7FFFFFFF, 64'h7FFFFFFF, 64'h3FFFFFFF, 9};
        vt[8]  = '{I_MULHSU, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 9};
        vt[9]  = '{I_MULHU,  64'h80000000, 64'h2,        64'h1,        9};
        vt[10] = '{I_MUL,    64'h12345678, 64'h10,       64'h23456780, 9};
        vt[11] = '{I_MULH,   64'hFFFFFFFB, 64'h3,        64'hFFFFFFFF, 9};
        vt[12] = '{I_MULHU,  64'h0,        64'hFFFFFFFF, 64'h0,        0};

        rstn = 1'b0; ex_stall = 1'b0; flush = 1'b0; bub = 3'b111;
        instr = 32'h0; a = 64'h0; b = 64'h0; st = RV32I;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("reset%0d stall", s), {63'h0, get_stall(s)}, 64'h0);
            chk($sformatf("reset%0d bubble", s), {63'h0, get_bub(s)}, 64'h1);
            chk($sformatf("reset%0d r", s), get_r(s), 64'h0);
        end
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++)
            run_op(0, vt[i].ins, vt[i].va, vt[i].vb, RV32I, vt[i].exp, vt[i].stalls,
                   $sformatf("vec%0d", i));

        ignore_op(0, I_ADD, 64'h5, 64'h5, RV32I, 64'h0, "ign_add");
        ignore_op(0, I_MULW, 64'h5, 64'h5, RV32I, 64'h0, "ign_mulw32");

        instr = I_MUL; a = 64'h5; b = 64'h5;
        @(posedge clk); #1;
        chk("id_bubble_blocks stall", {63'h0, stl0}, 64'h0);

        run_op(0, I_MUL, 64'h5, 64'h5, RV32I, 64'd25, 9, "mul5x5");

        // flush in the third BUSY cycle
        instr = I_MUL; a = 64'h11; b = 64'h22; bub[0] = 1'b0;
        @(posedge clk); #1;
        bub = 3'b111;
        repeat (2) begin @(posedge clk); #1; end
        chk("flush_busy pre stall", {63'h0, stl0}, 64'h1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy stall", {63'h0, stl0}, 64'h0);
        chk("flush_busy bubble", {63'h0, bb0}, 64'h1);
        chk("flush_busy r", {32'h0, r0}, 64'd25);
        saw = 0;
        repeat (12) begin @(posedge clk); #1; if (!bb0 || stl0) saw++; end
        chk("flush_busy quiet", 64'(saw), 64'h0);

        run_op(0, I_MUL, 64'h7, 64'h6, RV32I, 64'd42, 9, "mul7x6");

        // ex_stall blocks capture but not iteration
        ex_stall = 1'b1; instr = I_MUL; a = 64'h9; b = 64'h9; bub[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("ex_stall_blocks stall", {63'h0, stl0}, 64'h0);
        ex_stall = 1'b0;
        @(posedge clk); #1;
        bub = 3'b111; ex_stall = 1'b1;
        saw = 0;
        while (stl0 && saw < 200) begin @(posedge clk); #1; saw++; end
        ex_stall = 1'b0;
        chk("ex_stall_iter cycles", 64'(saw), 64'd9);
        chk("ex_stall_iter r", {32'h0, r0}, 64'd81);
        chk("ex_stall_iter bubble", {63'h0, bb0}, 64'h0);
        @(posedge clk); #1;

        // flush arriving with DONE
        instr = I_MUL; a = 64'h13; b = 64'h17; bub[0] = 1'b0;
        @(posedge clk); #1;
        bub = 3'b111;
        repeat (8) begin @(posedge clk); #1; end
        chk("flush_done pre stall", {63'h0, stl0}, 64'h1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_done stall", {63'h0, stl0}, 64'h0);
        chk("flush_done bubble", {63'h0, bb0}, 64'h1);
        chk("flush_done r", {32'h0, r0}, 64'd81);
        @(posedge clk); #1;

        run_op(0, I_MULH,  64'hFFFFFFFD, 64'h40000000, RV32I, 64'hFFFFFFFF, 9,       "fuse_mulh");
        run_op(0, I_MUL,   64'hFFFFFFFD, 64'h40000000, RV32I, 64'h40000000, FUSE_ST, "fuse_mul");
        run_op(0, I_MULHU, 64'hFFFFFFFD, 64'h40000000, RV32I, 64'h3FFFFFFF, 9,       "fuse_mulhu");
        run_op(0, I_MULHU, 64'hFFFFFFFD, 64'h40000000, RV32I, 64'h3FFFFFFF, FUSE_ST, "fuse_mulhu2");

        run_op(1, I_MUL, 64'h1234, 64'h0, RV32I, 64'h0,  9, "neo_zero");
        run_op(1, I_MUL, 64'h5,    64'h6, RV32I, 64'd30, 9, "neo_mul");

        run_op(2, I_MULW, 64'h7FFFFFFF, 64'h2, RV64I, 64'hFFFFFFFFFFFFFFFE, 5, "w64_mulw");
        ignore_op(2, I_MULW, 64'h7FFFFFFF, 64'h2, RV32I, 64'hFFFFFFFFFFFFFFFE, "w64_rv32i");
        run_op(2, I_MULW, 64'hFFFFFFFF80000000, 64'h00000000FFFFFFFF, RV64I,
               64'hFFFFFFFF80000000, 5, "w64_mulw_neg");
        run_op(2, I_MUL, 64'h3, 64'hFFFFFFFFFFFFFFFB, RV64I, 64'hFFFFFFFFFFFFFFF1, 9, "w64_mul");
        run_op(2, I_MULH, 64'h8000000000000000, 64'h8000000000000000, RV64I,
               64'h4000000000000000, 9, "w64_mulh");

        // reset in the middle of an operation
        instr = I_MUL; a = 64'h55; b = 64'h3; st = RV32I; bub[0] = 1'b0;
        @(posedge clk); #1;
        bub = 3'b111;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("rst_mid stall", {63'h0, stl0}, 64'h0);
        chk("rst_mid bubble", {63'h0, bb0}, 64'h1);
        chk("rst_mid r", {32'h0, r0}, 64'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        saw = 0;
        repeat (12) begin @(posedge clk); #1; if (!bb0 || stl0) saw++; end
        chk("rst_mid quiet", 64'(saw), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_mul_iter.md
Name: riscv_mul_iter

Overview:
Iterative radix-2^RADIX_BITS multiplier for the RV32M/RV64M multiply group: MUL, MULH, MULHSU, MULHU and MULW. It is the area-reduced successor to the single-array multiplier and sits in the EX stage beside the ALU. It uses the same stall/bubble handshake toward the pipeline. It adds configurable digit width, zero-operand early-out and in-flight flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
RADIX_BITS, 4, multiplier bits consumed per cycle; legal values 1, 2, 4, 8.
EARLY_OUT, 1, when 1 a zero operand completes with no stall.

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
ex_stall  in  1  EX stage stalled; blocks instruction capture only
flush  in  1  kill any in-flight multiply
mul_stall  out  1  unit busy; pipeline must hold
id_bubble  in  1  id_instr invalid
id_instr  in  32  instruction; decoded on func7/func3/opcode
opA  in  XLEN  rs1 operand
opB  in  XLEN  rs2 operand
st_xlen  in  2  current XLEN mode; RV32I constant means 32-bit
mul_bubble  out  1  low for exactly one cycle when mul_r is valid
mul_r  out  XLEN  result

Behaviour:
- Reset (rstn low, asynchronous):
  - state IDLE; mul_stall=0; mul_bubble=1; mul_r=0.
  - Reset mid-operation abandons the operation with no result.
- Decode:
  - Accepted ops are MUL, MULH, MULHSU, MULHU, plus MULW when XLEN=64 and st_xlen is not RV32I.
  - Any other instruction is ignored.
- Operand transform:
  - MULW: |sext32(op[31:0])| on both operands.
  - MULHU: both operands raw.
  - MULHSU: |opA| and raw opB.
  - Otherwise: |op| on both operands.
  - Negate flag: MUL/MULH use opA[msb]^opB[msb]; MULHSU uses opA[msb]; MULHU uses 0; MULW uses opA[31]^opB[31].
- Iteration count: ITER = XLEN/RADIX_BITS; MULW uses 32/RADIX_BITS.
- FSM states: IDLE, BUSY, DONE.
- IDLE, on an edge with !ex_stall && !id_bubble && valid op && !flush:
  - EARLY_OUT=1 and either transformed operand is zero: mul_r<=0, mul_bubble<=0 for one cycle, mul_stall stays 0, state stays IDLE.
  - Otherwise: latch multiplicand, multiplier, negate flag and op; clear the 2*XLEN accumulator; cnt<=ITER-1; mul_stall<=1; go to BUSY.
- BUSY, each cycle:
  - acc_hi += mcand*mplier[RADIX_BITS-1:0] (XLEN+RADIX_BITS bits wide).
  - Shift {acc, mplier} right by RADIX_BITS.
  - cnt==0 goes to DONE; otherwise cnt decrements.
  - ex_stall does not pause iteration.
- DONE, one cycle:
  - Product P is two's-complemented when the negate flag is set.
  - MUL: mul_r<=P[XLEN-1:0]. MULW: mul_r<=sext32(P[31:0]). MULH/MULHSU/MULHU: mul_r<=P[2XLEN-1:XLEN].
  - mul_bubble<=0 for one cycle; mul_stall<=0; go to IDLE.
- Latency:
  - mul_stall is high for ITER+1 cycles after the accepting edge.
  - mul_r and mul_bubble=0 become visible in the same cycle that mul_stall falls.
  - Example: XLEN=32, RADIX_BITS=4 gives 9 stall cycles.
- Flush:
  - In BUSY or DONE: go to IDLE, mul_stall<=0, mul_bubble stays 1, mul_r unchanged.
  - In IDLE, flush suppresses capture.
  - Flush wins over a simultaneous DONE.
- A new multiply is accepted only from IDLE. Back-to-back multiplies cost ITER+1 cycles each plus one IDLE capture edge.
- mul_bubble defaults to 1 every cycle unless set low as above.

Optional Feature:
RISCV_MUL_FUSE_EN
- Defined:
  - A one-entry cache holds raw opA, raw opB, the operand-transform class and the signed 2*XLEN product of the last completed op (not the early-out path).
  - A new op whose raw operands match and whose transform class and negate flag match completes from IDLE like early-out: result on the next cycle, no stall.
  - This covers, for example, MULH followed by MUL on the same registers.
  - Reset clears the cache valid bit.
  - flush does not invalidate an entry written by a completed op.
- Undefined: no cache; every op iterates.

Decomposition:
- riscv_pkg gains typedef mul_op_t {MOP_MUL, MOP_MULH, MOP_MULHSU, MOP_MULHU, MOP_MULW}.
- Existing MUL/MULH/MULHSU/MULHU/MULW instruction patterns and RV32I are reused.
- One sub-module: riscv_mul_step, the combinational radix step (mcand, acc_hi, digit -> new acc_hi, shifted low bits), parametrised by XLEN and RADIX_BITS.

Test Plan:
- XLEN=32, RADIX_BITS=4: MUL 3 * 0xFFFFFFFB -> mul_stall high 9 cycles, mul_r=0xFFFFFFF1, mul_bubble low one cycle.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- EARLY_OUT=1: MUL 0x1234*0 -> mul_r=0 on the next cycle, mul_stall never high. With EARLY_OUT=0 -> 9 stall cycles, mul_r=0.
- Flush in BUSY cycle 3 -> mul_stall drops on the next edge, no mul_bubble pulse, mul_r keeps its previous value. A following MUL 7*6 -> 42.
- XLEN=64, RADIX_BITS=8, st_xlen=RV64: MULW 0x7FFFFFFF*2 -> 0xFFFFFFFFFFFFFFFE after 5 stall cycles. The same instruction with st_xlen=RV32I is ignored.
- RISCV_MUL_FUSE_EN: MULH a,b then MUL a,b -> second result with no stall, correct low word. MULHU a,b after MULH a,b -> full iteration.
